me_mem_loader: RTL and testbench

Write-side companion to the motion-estimation control block. Accepts a byte stream holding one 16x16 current block followed by its reference search window. Packs the bytes little-endian into 64-bit words and writes them into the current-block memory and the reference-window memory. After the last write lands, it pulses `go` to start the control block.

---
 rtl/me_mem_loader_pkg.sv | 25 ++
 rtl/me_mem_loader_byte_packer.sv | 39 +++
 rtl/me_mem_loader.sv | 135 +++++++++++++
 tb/tb_me_mem_loader.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/me_mem_loader_pkg.sv
// Shared constants, state encoding and reference-window sizing for the ME memory loader.
package me_mem_loader_pkg;

  localparam int unsigned max_r           = 2;
  localparam int unsigned cur_addr_max    = 5;
  localparam int unsigned REF_ADDR_W      = 8;
  localparam int unsigned DATA_W          = 64;
  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned CUR_WORDS       = 32;
  localparam int unsigned REF_WORDS_PER_R = 64;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_CUR = 3'd1,
    ST_LOAD_REF = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_GO       = 3'd4
  } state_e;

  // Address of the final reference word for search range r: 64*(r+1) - 1.
  function automatic logic [REF_ADDR_W-1:0] ref_last_word(input logic [max_r-1:0] r);
    return REF_ADDR_W'((32'(r) + 32'd1) * REF_WORDS_PER_R - 32'd1);
  endfunction

endpackage

// File: rtl/me_mem_loader_byte_packer.sv
// Little-endian byte-to-word packer shared by the current and reference memories.
module me_mem_loader_byte_packer
  import me_mem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic              word_done_c_o,
  output logic [DATA_W-1:0] word_c_o
);

  logic [2:0]        lane_q;
  logic [DATA_W-1:0] word_q;

  // Lane index and partial word; clear rewinds to lane 0 between loads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q <= 3'd0;
      word_q <= '0;
    end else if (clear_i) begin
      lane_q <= 3'd0;
      word_q <= '0;
    end else if (accept_i) begin
      word_q[{lane_q, 3'b000} +: BYTE_W] <= data_i;
      lane_q                             <= lane_q + 3'd1;
    end
  end

  // Completed word includes the byte being accepted this cycle in its lane.
  always_comb begin
    word_c_o                              = word_q;
    word_c_o[{lane_q, 3'b000} +: BYTE_W]  = data_i;
  end

  assign word_done_c_o = accept_i && (lane_q == 3'd7);

endmodule

// File: rtl/me_mem_loader.sv
// Streams one current block plus its reference window into the two ME memories, then pulses go.
module me_mem_loader
  import me_mem_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic [max_r-1:0]        r,
  input  logic                    load_start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BYTE_W-1:0]       in_data,
  output logic                    wenCur,
  output logic [cur_addr_max-1:0] waddrCur,
  output logic [DATA_W-1:0]       wdatCur,
  output logic                    wenRef,
  output logic [REF_ADDR_W-1:0]   waddrRef,
  output logic [DATA_W-1:0]       wdatRef,
  output logic                    go,
  output logic                    busy
);

  localparam logic [cur_addr_max-1:0] CUR_LAST = cur_addr_max'(CUR_WORDS - 1);

  state_e                  state_q;
  logic [max_r-1:0]        r_q;
  logic [cur_addr_max-1:0] cur_cnt_q;
  logic [REF_ADDR_W-1:0]   ref_cnt_q;
  logic                    in_ready_q;
  logic                    busy_q;
  logic                    go_q;
  logic                    wen_cur_q;
  logic [cur_addr_max-1:0] waddr_cur_q;
  logic [DATA_W-1:0]       wdat_cur_q;
  logic                    wen_ref_q;
  logic [REF_ADDR_W-1:0]   waddr_ref_q;
  logic [DATA_W-1:0]       wdat_ref_q;

  logic                    accept_c;
  logic                    word_done_c;
  logic [DATA_W-1:0]       word_c;

  assign accept_c = in_valid && in_ready_q;

  me_mem_loader_byte_packer u_byte_packer (
    .clk           (clk),
    .reset         (reset),
    .clear_i       (state_q == ST_IDLE),
    .accept_i      (accept_c),
    .data_i        (in_data),
    .word_done_c_o (word_done_c),
    .word_c_o      (word_c)
  );

  // Load sequencer: state, address counters, write steering and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      r_q         <= '0;
      cur_cnt_q   <= '0;
      ref_cnt_q   <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      go_q        <= 1'b0;
      wen_cur_q   <= 1'b0;
      waddr_cur_q <= '0;
      wdat_cur_q  <= '0;
      wen_ref_q   <= 1'b0;
      waddr_ref_q <= '0;
      wdat_ref_q  <= '0;
    end else begin
      wen_cur_q <= 1'b0;
      wen_ref_q <= 1'b0;
      go_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            r_q        <= r;
            cur_cnt_q  <= '0;
            ref_cnt_q  <= '0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_LOAD_CUR;
          end
        end
        ST_LOAD_CUR: begin
          if (word_done_c) begin
            wen_cur_q   <= 1'b1;
            waddr_cur_q <= cur_cnt_q;
            wdat_cur_q  <= word_c;
            cur_cnt_q   <= cur_cnt_q + 1'b1;
            if (cur_cnt_q == CUR_LAST) begin
              state_q <= ST_LOAD_REF;
            end
          end
        end
        ST_LOAD_REF: begin
          if (word_done_c) begin
            wen_ref_q   <= 1'b1;
            waddr_ref_q <= ref_cnt_q;
            wdat_ref_q  <= word_c;
            ref_cnt_q   <= ref_cnt_q + 1'b1;
            if (ref_cnt_q == ref_last_word(r_q)) begin
              in_ready_q <= 1'b0;
              state_q    <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          go_q    <= 1'b1;
          state_q <= ST_GO;
        end
        ST_GO: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign go       = go_q;
  assign wenCur   = wen_cur_q;
  assign waddrCur = waddr_cur_q;
  assign wdatCur  = wdat_cur_q;
  assign wenRef   = wen_ref_q;
  assign waddrRef = waddr_ref_q;
  assign wdatRef  = wdat_ref_q;

endmodule

// File: tb/tb_me_mem_loader.sv
// Directed bench for me_mem_loader: continuous, gapped, range-change and reset-abort loads.
module tb_me_mem_loader;
  import me_mem_loader_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [max_r-1:0]        r;
  logic                    load_start;
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              in_data;
  logic                    wenCur;
  logic [cur_addr_max-1:0] waddrCur;
  logic [63:0]             wdatCur;
  logic                    wenRef;
  logic [7:0]              waddrRef;
  logic [63:0]             wdatRef;
  logic                    go;
  logic                    busy;

  int total = 0;
  int bad   = 0;
  int cur_wr, ref_wr, go_cnt, both_err, addr_err, data_err, busy_drop;
  bit loading = 1'b0;
  logic [63:0] cur_word0;

  me_mem_loader dut (
    .clk        (clk),
    .reset      (rst_n),
    .r          (r),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .wenCur     (wenCur),
    .waddrCur   (waddrCur),
    .wdatCur    (wdatCur),
    .wenRef     (wenRef),
    .waddrRef   (waddrRef),
    .wdatRef    (wdatRef),
    .go         (go),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Word whose lane i holds byte value (base+i) mod 256.
  function automatic logic [63:0] exp_word(input int base);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = 8'((base + i) % 256);
    return w;
  endfunction

  // Called once per falling edge: tallies writes against the stream model.
  task automatic sample();
    if (wenCur && wenRef) both_err++;
    if (wenCur) begin
      if (waddrCur == '0) cur_word0 = wdatCur;
      if (waddrCur !== cur_addr_max'(cur_wr)) addr_err++;
      if (wdatCur !== exp_word(8 * cur_wr)) data_err++;
      cur_wr++;
    end
    if (wenRef) begin
      if (waddrRef !== 8'(ref_wr)) addr_err++;
      if (wdatRef !== exp_word(8 * ref_wr)) data_err++;
      ref_wr++;
    end
    if (go) go_cnt++;
    if (loading && !busy) busy_drop++;
  endtask

  // One load; byte i of the stream is i mod 256. abort_at >= 0 stops after that many bytes.
  task automatic run_load(input string tag, input logic [1:0] rv, input int gap,
                          input int disturb_at, input int abort_at);
    int n_ref, nbytes, idx, cyc;
    n_ref  = 64 * (int'(rv) + 1);
    nbytes = (abort_at >= 0) ? abort_at : 256 + 8 * n_ref;
    cur_wr = 0; ref_wr = 0; go_cnt = 0; both_err = 0;
    addr_err = 0; data_err = 0; busy_drop = 0;
    cur_word0 = '0;
    @(negedge clk); sample();
    r = rv; load_start = 1'b1;
    @(negedge clk); sample();
    load_start = 1'b0;
    check({tag, "_start_busy_ready"}, 64'({busy, in_ready}), 64'(2'b11));
    loading = 1'b1;
    idx = 0; cyc = 0;
    while (idx < nbytes && cyc < 20000) begin
      in_valid   = (gap == 0) || (int'($urandom_range(99)) >= gap);
      in_data    = 8'(idx % 256);
      load_start = (disturb_at >= 0) && (idx == disturb_at);
      if (disturb_at >= 0 && idx >= disturb_at) r = 2'd3;
      if (in_valid && in_ready) idx++;
      @(negedge clk); sample();
      cyc++;
    end
    in_valid = 1'b0; load_start = 1'b0;
    check({tag, "_bytes_accepted"}, 64'(idx), 64'(nbytes));
    if (abort_at < 0) begin
      check({tag, "_drain_wenref_go"}, 64'({wenRef, go}), 64'(2'b10));
      check({tag, "_drain_addr"}, 64'(waddrRef), 64'(n_ref - 1));
      @(negedge clk); sample();
      check({tag, "_go_busy"}, 64'({go, busy}), 64'(2'b11));
      loading = 1'b0;
      @(negedge clk); sample();
      check({tag, "_after_go"}, 64'({go, busy, in_ready}), 64'(3'b000));
      check({tag, "_cur_writes"}, 64'(cur_wr), 64'(32));
      check({tag, "_ref_writes"}, 64'(ref_wr), 64'(n_ref));
      check({tag, "_go_count"}, 64'(go_cnt), 64'(1));
      check({tag, "_addr_seq_err"}, 64'(addr_err), 64'(0));
      check({tag, "_data_err"}, 64'(data_err), 64'(0));
      check({tag, "_both_wen"}, 64'(both_err), 64'(0));
      check({tag, "_busy_drop"}, 64'(busy_drop), 64'(0));
      check({tag, "_cur_word0"}, cur_word0, 64'h0706050403020100);
      if (gap == 0) check({tag, "_throughput_cycles"}, 64'(cyc), 64'(nbytes));
    end
  endtask

  initial begin
    rst_n = 1'b0; r = '0; load_start = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    check("reset_ctrl", 64'({in_ready, wenCur, wenRef, go, busy}), 64'(0));
    check("reset_waddrcur", 64'(waddrCur), 64'(0));
    check("reset_waddrref", 64'(waddrRef), 64'(0));
    check("reset_wdatcur", wdatCur, 64'(0));
    check("reset_wdatref", wdatRef, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_load("r0", 2'd0, 0, -1, -1);
    run_load("r3", 2'd3, 0, -1, -1);
    run_load("gap30", 2'd0, 30, -1, -1);
    run_load("rchg", 2'd1, 0, 256 + 40, -1);

    // Abort after 100 reference bytes.
    run_load("abort", 2'd2, 0, -1, 256 + 100);
    rst_n = 1'b0;
    loading = 1'b0;
    #1;
    check("abort_ctrl_zero", 64'({in_ready, wenCur, wenRef, go, busy}), 64'(0));
    check("abort_waddrref", 64'(waddrRef), 64'(0));
    check("abort_wdatref", wdatRef, 64'(0));
    repeat (5) begin
      @(negedge clk); sample();
    end
    check("abort_no_go", 64'(go_cnt), 64'(0));
    rst_n = 1'b1;
    run_load("post_abort", 2'd0, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
